pe_flow_cell: RTL and testbench
===============================

// Module: pe_flow_cell
// PURPOSE
//  Parametrised successor of the PE enable/data forwarding cell in the systolic tensor array.
//  Registers left->right and above->below operand/enable flow through FWD_STAGES stages.
//  Drives the local compute enable.
//  Latches the compute mode once per tile and forwards it once, instead of every cycle.
//  Tracks tile boundaries through an IDLE/BUSY/DRAIN FSM and a beat counter.
// PARAMETERS
//  DATA_W      32  operand width, both directions
//  FWD_STAGES  1   forwarding pipeline depth per direction, legal 1..4
//  CNT_W       8   beat counter width
//  ZERO_IDLE   1   1: disabled stage loads 0; 0: disabled stage holds its data (toggle saving)
// PORTS
//  clk            in   1             clock, all logic on posedge
//  rst_n          in   1             asynchronous active-low reset
//  en_left        in   1             operand-valid from left neighbour
//  data_left      in   DATA_W        operand from left neighbour
//  en_above       in   1             operand-valid from upper neighbour
//  data_above     in   DATA_W        operand from upper neighbour
//  en_right       out  1             en_left delayed FWD_STAGES cycles
//  data_right     out  DATA_W        data_left delayed FWD_STAGES cycles
//  en_below       out  1             en_above delayed FWD_STAGES cycles
//  data_below     out  DATA_W        data_above delayed FWD_STAGES cycles
//  en             out  1             local MAC enable = en_left & en_above, combinational
//  cfg_valid_in   in   1             compute-mode update pulse
//  cfg_mode_in    in   addrgen_t     new compute mode (params::addrgen_t)
//  cfg_valid_out  out  1             one-cycle pulse when the mode is applied; feeds next cell
//  cfg_mode_out   out  addrgen_t     applied mode; stable between updates
//  beat_cnt       out  CNT_W         enabled beats in the current or last tile
//  tile_done      out  1             one-cycle pulse when a tile has fully drained
//  err_mismatch   out  1             sticky enable-mismatch flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: all outputs 0; all pipe stages 0; FSM=IDLE; no pending cfg; cfg_mode_out=0.
//  Forward pipe, per direction, on each clk:
//   - stage0.en <= en_x.
//   - stage0.data <= data_x when en_x=1.
//   - When en_x=0, stage0.data <= 0 if ZERO_IDLE=1; otherwise it holds its value.
//   - stage k <= stage k-1. Outputs are the last stage, so latency is exactly FWD_STAGES.
//  FSM states:
//   - IDLE: en=1 -> BUSY; beat_cnt <= 1.
//   - BUSY, en=1: beat_cnt += 1, saturating at 2^CNT_W-1.
//   - BUSY, en=0: -> DRAIN; drain_cnt <= 0.
//   - DRAIN: drain_cnt increments each cycle. If en=1 -> BUSY, same tile: beat_cnt += 1, no tile_done.
//   - DRAIN, drain_cnt==FWD_STAGES-1 with en=0: tile_done=1 for one cycle; -> IDLE.
//   - beat_cnt holds its value in IDLE until the next tile starts.
//  Config:
//   - cfg_valid_in in IDLE: cfg_mode_out <= cfg_mode_in and cfg_valid_out=1, both next cycle.
//   - cfg_valid_in in BUSY/DRAIN: the mode is stored as pending; the last request wins.
//   - A pending mode is applied in the cycle the FSM enters IDLE, pulsing cfg_valid_out then.
//   - cfg_valid_in in that same cycle overrides the pending mode; exactly one pulse results.
//   - The mode never changes mid-tile.
//  Reset asserted mid-tile: everything clears immediately, including pending cfg; no tile_done.
// CONFIGURATION
//  Macro PE_ENABLE_CHECK_EN:
//   - Defined: on any clk edge with en_left!=en_above, err_mismatch <= 1 (sticky until rst_n).
//     A simulation $error is also raised.
//   - Undefined: err_mismatch is tied to 0; no check logic and no assertion.
// TESTING
//  1. FWD_STAGES=2: en_left=en_above=1, data_left=0xA5A5_0001 at cycle 0.
//     -> en=1 at cycle 0; data_right=0xA5A5_0001 and en_right=1 exactly 2 cycles later.
//  2. ZERO_IDLE=1 vs 0: 3 enabled beats, then en low.
//     -> data_right reads 0 (ZERO_IDLE=1) or the last value (ZERO_IDLE=0).
//  3. FWD_STAGES=1, 5 enabled beats. -> beat_cnt=5; tile_done pulses once, 1 cycle after en drops.
//     Repeat with a 1-cycle en gap in DRAIN (FWD_STAGES=2). -> one tile, beat_cnt=6, no early pulse.
//  4. cfg_valid_in with mode=2 during BUSY. -> cfg_mode_out unchanged until the tile drains.
//     Then cfg_valid_out pulses once with mode 2.
//     cfg_valid_in in IDLE. -> applied with a 1-cycle pulse.
//  5. CNT_W=4, 20 beats. -> beat_cnt saturates at 15.
//     rst_n low for 1 cycle mid-tile. -> all outputs 0 immediately; no tile_done.
//  6. PE_ENABLE_CHECK_EN defined: en_left=1, en_above=0 for 1 cycle.
//     -> err_mismatch=1 and stays 1 until rst_n. Undefined: err_mismatch stays 0.

Source files
------------

// File: rtl/pe_flow_cell.sv
// pe_flow_cell: systolic-array PE enable/data forwarding cell.
// Forwards left->right and above->below operands through FWD_STAGES register
// stages, drives the local MAC enable, tracks tile boundaries and forwards the
// compute mode once per tile.
// Optional build macro: PE_ENABLE_CHECK_EN adds a sticky en_left/en_above
// mismatch flag plus a simulation assertion.
//
// state | meaning
// IDLE  | no tile in flight; mode updates are applied directly
// BUSY  | tile streaming, local enable high
// DRAIN | enable dropped; waiting for the forwarding pipe to empty

package params;
    typedef logic [3:0] addrgen_t;
endpackage

module pe_flow_cell
    import params::*;
#(
    parameter int DATA_W     = 32,
    parameter int FWD_STAGES = 1,
    parameter int CNT_W      = 8,
    parameter int ZERO_IDLE  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_left,
    input  logic [DATA_W-1:0] data_left,
    input  logic              en_above,
    input  logic [DATA_W-1:0] data_above,
    output logic              en_right,
    output logic [DATA_W-1:0] data_right,
    output logic              en_below,
    output logic [DATA_W-1:0] data_below,
    output logic              en,
    input  logic              cfg_valid_in,
    input  addrgen_t          cfg_mode_in,
    output logic              cfg_valid_out,
    output addrgen_t          cfg_mode_out,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              tile_done,
    output logic              err_mismatch
);

    // One pipe entry carries both directions: {en_a, data_a, en_l, data_l}
    localparam int LANE_W = DATA_W + 1;
    localparam int PIPE_W = 2 * LANE_W;
    localparam logic [1:0]       DRAIN_LAST = 2'(FWD_STAGES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    logic [FWD_STAGES-1:0][PIPE_W-1:0] pipe_q;
    logic [FWD_STAGES-1:0][PIPE_W-1:0] pipe_nxt;
    logic [PIPE_W-1:0]                 head;
    logic [DATA_W-1:0]                 idle_l;
    logic [DATA_W-1:0]                 idle_a;

    state_t           state;
    logic [1:0]       drain_cnt;
    logic             pend_valid;
    addrgen_t         pend_mode;
    logic [CNT_W-1:0] beat_inc;

    assign en = en_left & en_above;

    // A disabled first stage either loads zero or keeps its last operand
    assign idle_l = (ZERO_IDLE != 0) ? '0 : pipe_q[0][DATA_W-1:0];
    assign idle_a = (ZERO_IDLE != 0) ? '0 : pipe_q[0][LANE_W +: DATA_W];
    assign head   = {en_above, en_above ? data_above : idle_a,
                     en_left,  en_left  ? data_left  : idle_l};

    if (FWD_STAGES == 1) begin : g_one
        assign pipe_nxt = head;
    end else begin : g_chain
        assign pipe_nxt = {pipe_q[FWD_STAGES-2:0], head};
    end

    assign {en_below, data_below, en_right, data_right} = pipe_q[FWD_STAGES-1];

    assign beat_inc = (beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + 1'b1;

    // Forwarding pipe: shift one stage per clock in both directions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_nxt;
        end
    end

    // Tile FSM with beat counter and once-per-tile mode forwarding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            drain_cnt     <= '0;
            beat_cnt      <= '0;
            tile_done     <= 1'b0;
            cfg_valid_out <= 1'b0;
            cfg_mode_out  <= '0;
            pend_valid    <= 1'b0;
            pend_mode     <= '0;
        end else begin
            tile_done     <= 1'b0;
            cfg_valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid_in) begin
                        cfg_mode_out  <= cfg_mode_in;
                        cfg_valid_out <= 1'b1;
                    end
                    if (en) begin
                        state    <= BUSY;
                        beat_cnt <= CNT_W'(1);
                    end
                end
                BUSY: begin
                    if (cfg_valid_in) begin
                        pend_mode  <= cfg_mode_in;
                        pend_valid <= 1'b1;
                    end
                    if (en) begin
                        beat_cnt <= beat_inc;
                    end else begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (cfg_valid_in) begin
                        pend_mode  <= cfg_mode_in;
                        pend_valid <= 1'b1;
                    end
                    if (en) begin
                        // enable came back before the pipe emptied: same tile
                        state    <= BUSY;
                        beat_cnt <= beat_inc;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state      <= IDLE;
                        tile_done  <= 1'b1;
                        pend_valid <= 1'b0;
                        // a request arriving on the exit edge beats the stored one
                        if (cfg_valid_in) begin
                            cfg_mode_out  <= cfg_mode_in;
                            cfg_valid_out <= 1'b1;
                        end else if (pend_valid) begin
                            cfg_mode_out  <= pend_mode;
                            cfg_valid_out <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PE_ENABLE_CHECK_EN
    // Sticky flag: neighbours disagree on operand validity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mismatch <= 1'b0;
        end else if (en_left != en_above) begin
            err_mismatch <= 1'b1;
        end
    end

    en_match_a: assert property (@(posedge clk) disable iff (!rst_n) en_left == en_above)
        else $error("pe_flow_cell: en_left/en_above mismatch");
`else
    assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_pe_flow_cell.sv
// Bench for pe_flow_cell: two instances with different parameter sets share
// one stimulus stream and are compared against a cycle-history reference model.

module tb_pe_flow_cell;
    import params::*;

`ifdef PE_ENABLE_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_left, en_above;
    logic [31:0] data_left, data_above;
    logic        cfg_valid_in;
    addrgen_t    cfg_mode_in;

    logic        o_er[2], o_eb[2], o_en[2], o_cv[2], o_td[2], o_err[2];
    logic [31:0] o_dr[2], o_db[2];
    addrgen_t    o_cm[2];
    logic [7:0]  o_bc[2];
    logic [3:0]  a_bc;

    int n_pass = 0;
    int n_total = 0;

    // model state
    int       ecount = 0;
    int       base = 0;
    logic     hel[0:4095], hea[0:4095];
    logic [31:0] hdl[0:4095], hda[0:4095];
    bit       m_in[2], m_done[2], m_cv[2], m_pv[2], m_err[2];
    int       m_zero[2], m_beats[2];
    addrgen_t m_mode[2], m_pend[2];
    int       t_ndone[2], t_at[2];

    always #5 clk = ~clk;

    assign o_bc[0] = {4'b0, a_bc};

    pe_flow_cell #(.DATA_W(32), .FWD_STAGES(2), .CNT_W(4), .ZERO_IDLE(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .en_left(en_left), .data_left(data_left), .en_above(en_above), .data_above(data_above),
        .en_right(o_er[0]), .data_right(o_dr[0]), .en_below(o_eb[0]), .data_below(o_db[0]),
        .en(o_en[0]), .cfg_valid_in(cfg_valid_in), .cfg_mode_in(cfg_mode_in),
        .cfg_valid_out(o_cv[0]), .cfg_mode_out(o_cm[0]), .beat_cnt(a_bc),
        .tile_done(o_td[0]), .err_mismatch(o_err[0])
    );

    pe_flow_cell #(.DATA_W(32), .FWD_STAGES(1), .CNT_W(8), .ZERO_IDLE(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .en_left(en_left), .data_left(data_left), .en_above(en_above), .data_above(data_above),
        .en_right(o_er[1]), .data_right(o_dr[1]), .en_below(o_eb[1]), .data_below(o_db[1]),
        .en(o_en[1]), .cfg_valid_in(cfg_valid_in), .cfg_mode_in(cfg_mode_in),
        .cfg_valid_out(o_cv[1]), .cfg_mode_out(o_cm[1]), .beat_cnt(o_bc[1]),
        .tile_done(o_td[1]), .err_mismatch(o_err[1])
    );

    function automatic int fwd(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic bit zi(input int d);
        return (d == 0);
    endfunction

    function automatic int cmax(input int d);
        return (d == 0) ? 15 : 255;
    endfunction

    // {en, data} held by the first stage after edge m
    function automatic logic [32:0] s0(input bit left, input int m, input bit zero_idle);
        if (m < base) return '0;
        if (left ? hel[m] : hea[m]) return {1'b1, left ? hdl[m] : hda[m]};
        if (zero_idle) return '0;
        for (int j = m - 1; j >= base; j--)
            if (left ? hel[j] : hea[j]) return {1'b0, left ? hdl[j] : hda[j]};
        return '0;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_in[d] = 0; m_done[d] = 0; m_cv[d] = 0; m_pv[d] = 0; m_err[d] = 0;
            m_zero[d] = 0; m_beats[d] = 0; m_mode[d] = '0; m_pend[d] = '0;
        end
        base = ecount;
    endtask

    // A tile ends after FWD+1 consecutive edges without enable
    task automatic model_edge(input int d, input bit e, input bit cv, input addrgen_t cm, input bit mm);
        m_done[d] = 0;
        m_cv[d] = 0;
        if (CHK_EN && mm) m_err[d] = 1;
        if (!m_in[d]) begin
            if (cv) begin m_mode[d] = cm; m_cv[d] = 1; end
            if (e) begin m_in[d] = 1; m_zero[d] = 0; m_beats[d] = 1; end
        end else if (e) begin
            m_zero[d] = 0;
            if (m_beats[d] < cmax(d)) m_beats[d]++;
            if (cv) begin m_pend[d] = cm; m_pv[d] = 1; end
        end else begin
            m_zero[d]++;
            if (m_zero[d] == fwd(d) + 1) begin
                m_in[d] = 0;
                m_done[d] = 1;
                if (cv) begin m_mode[d] = cm; m_cv[d] = 1; end
                else if (m_pv[d]) begin m_mode[d] = m_pend[d]; m_cv[d] = 1; end
                m_pv[d] = 0;
            end else if (cv) begin
                m_pend[d] = cm; m_pv[d] = 1;
            end
        end
    endtask

    task automatic tick();
        bit e, cv, mm;
        addrgen_t cm;
        hel[ecount] = en_left;  hdl[ecount] = data_left;
        hea[ecount] = en_above; hda[ecount] = data_above;
        e = en_left & en_above; cv = cfg_valid_in; cm = cfg_mode_in; mm = (en_left != en_above);
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d, e, cv, cm, mm);
        ecount++;
        #1;
    endtask

    task automatic drive(input bit e, input bit cv, input addrgen_t cm);
        en_left = e; en_above = e;
        data_left = $urandom; data_above = $urandom;
        cfg_valid_in = cv; cfg_mode_in = cm;
    endtask

    task automatic run_pat(input logic [15:0] pat, input int len);
        for (int d = 0; d < 2; d++) begin t_ndone[d] = 0; t_at[d] = -1; end
        for (int i = 0; i < len; i++) begin
            drive(pat[i], 1'b0, '0);
            tick();
            for (int d = 0; d < 2; d++)
                if (o_td[d] === 1'b1) begin t_ndone[d]++; if (t_at[d] < 0) t_at[d] = i; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if ({o_er[d], o_dr[d], o_eb[d], o_db[d], o_en[d], o_cv[d], o_cm[d], o_bc[d], o_td[d], o_err[d]} !== '0)
                $display("FAIL reset dut%0d: outputs not all zero (dr=%h bc=%0d cm=%0d)", d, o_dr[d], o_bc[d], o_cm[d]);
            else n_pass++;
        end
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_latency();
        drive(1'b1, 1'b0, '0);
        data_left = 32'hA5A5_0001;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_en[d] !== 1'b1) $display("FAIL latency_en dut%0d got %b want 1", d, o_en[d]);
            else n_pass++;
        end
        tick();
        drive(1'b0, 1'b0, '0);
        n_total++;
        if ({o_er[1], o_dr[1]} !== {1'b1, 32'hA5A5_0001})
            $display("FAIL latency_fwd1 got %b/%h want 1/a5a50001", o_er[1], o_dr[1]);
        else n_pass++;
        n_total++;
        if (o_er[0] !== 1'b0) $display("FAIL latency_fwd2_early got en_right=%b want 0", o_er[0]);
        else n_pass++;
        tick();
        n_total++;
        if ({o_er[0], o_dr[0]} !== {1'b1, 32'hA5A5_0001})
            $display("FAIL latency_fwd2 got %b/%h want 1/a5a50001", o_er[0], o_dr[0]);
        else n_pass++;
        repeat (4) tick();
    endtask

    task automatic test_zero_idle();
        logic [31:0] last;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, '0);
            last = data_left;
            tick();
        end
        for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b0, '0); tick(); end
        n_total++;
        if ({o_er[0], o_dr[0]} !== 33'h0) $display("FAIL zero_idle1 got %b/%h want 0/0", o_er[0], o_dr[0]);
        else n_pass++;
        n_total++;
        if ({o_er[1], o_dr[1]} !== {1'b0, last}) $display("FAIL zero_idle0 got %b/%h want 0/%h", o_er[1], o_dr[1], last);
        else n_pass++;
        repeat (3) tick();
    endtask

    task automatic test_tile();
        run_pat(16'b0000_0000_0001_1111, 11);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (t_ndone[d] !== 1 || t_at[d] !== (d == 0 ? 7 : 6) || o_bc[d] !== 8'd5)
                $display("FAIL tile5 dut%0d got done=%0d at=%0d bc=%0d want 1/%0d/5", d, t_ndone[d], t_at[d], o_bc[d], d == 0 ? 7 : 6);
            else n_pass++;
        end
        run_pat(16'b0000_0000_0111_0111, 12);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (t_ndone[d] !== 1 || t_at[d] !== (d == 0 ? 9 : 8) || o_bc[d] !== 8'd6)
                $display("FAIL tile_gap dut%0d got done=%0d at=%0d bc=%0d want 1/%0d/6", d, t_ndone[d], t_at[d], o_bc[d], d == 0 ? 9 : 8);
            else n_pass++;
        end
    endtask

    task automatic test_cfg();
        int np[2], pat[2], dat[2];
        bit early[2];
        for (int d = 0; d < 2; d++) begin np[d] = 0; pat[d] = -1; dat[d] = -1; early[d] = 0; end
        for (int i = 0; i < 10; i++) begin
            drive(i < 4, i == 1, 4'd2);
            tick();
            for (int d = 0; d < 2; d++) begin
                if (o_cv[d] === 1'b1) begin np[d]++; pat[d] = i; end
                if (o_td[d] === 1'b1) dat[d] = i;
                if (dat[d] < 0 && o_cm[d] !== 4'd0) early[d] = 1;
            end
        end
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (np[d] !== 1 || pat[d] !== (d == 0 ? 6 : 5) || dat[d] !== pat[d] || early[d] || o_cm[d] !== 4'd2)
                $display("FAIL cfg_busy dut%0d got pulses=%0d at=%0d done_at=%0d early=%0d mode=%0d want 1/%0d/%0d/0/2",
                         d, np[d], pat[d], dat[d], early[d], o_cm[d], d == 0 ? 6 : 5, d == 0 ? 6 : 5);
            else n_pass++;
        end
        drive(1'b0, 1'b1, 4'd5);
        tick();
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if ({o_cv[d], o_cm[d]} !== {1'b1, 4'd5}) $display("FAIL cfg_idle dut%0d got %b/%0d want 1/5", d, o_cv[d], o_cm[d]);
            else n_pass++;
        end
        drive(1'b0, 1'b0, 4'd9);
        tick();
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if ({o_cv[d], o_cm[d]} !== {1'b0, 4'd5}) $display("FAIL cfg_idle_pulse dut%0d got %b/%0d want 0/5", d, o_cv[d], o_cm[d]);
            else n_pass++;
        end
    endtask

    task automatic test_saturate_reset();
        bit seen[2];
        for (int i = 0; i < 20; i++) begin drive(1'b1, 1'b0, '0); tick(); end
        n_total++;
        if (o_bc[0] !== 8'd15) $display("FAIL saturate_cnt4 got %0d want 15", o_bc[0]);
        else n_pass++;
        n_total++;
        if (o_bc[1] !== 8'd20) $display("FAIL count_cnt8 got %0d want 20", o_bc[1]);
        else n_pass++;
        drive(1'b1, 1'b1, 4'd7);
        tick();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if ({o_er[d], o_dr[d], o_eb[d], o_db[d], o_cv[d], o_cm[d], o_bc[d], o_td[d], o_err[d]} !== '0)
                $display("FAIL reset_mid dut%0d: outputs not zero (bc=%0d cm=%0d dr=%h)", d, o_bc[d], o_cm[d], o_dr[d]);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        seen[0] = 0; seen[1] = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            for (int d = 0; d < 2; d++) if (o_td[d] !== 1'b0 || o_cv[d] !== 1'b0 || o_cm[d] !== 4'd0) seen[d] = 1;
        end
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (seen[d]) $display("FAIL reset_no_done dut%0d: tile_done/cfg pulse or mode seen after reset, want none", d);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int idle_run = 0;
        bit el, ea;
        logic [32:0] xl, xa;
        for (int c = 0; c < 400; c++) begin
            if (idle_run > 0) begin el = 0; idle_run--; end
            else begin
                el = ($urandom % 4) != 0;
                if ($urandom % 10 == 0) idle_run = $urandom_range(1, 4);
            end
            ea = ($urandom % 12 == 0) ? !el : el;
            en_left = el; en_above = ea;
            data_left = $urandom; data_above = $urandom;
            cfg_valid_in = ($urandom % 8) == 0;
            cfg_mode_in = addrgen_t'($urandom);
            #1;
            for (int d = 0; d < 2; d++) begin
                n_total++;
                if (o_en[d] !== (el & ea)) $display("FAIL rand_en dut%0d cyc%0d got %b want %b", d, c, o_en[d], el & ea);
                else n_pass++;
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                xl = s0(1'b1, ecount - fwd(d), zi(d));
                xa = s0(1'b0, ecount - fwd(d), zi(d));
                n_total++;
                if ({o_er[d], o_dr[d], o_eb[d], o_db[d]} !== {xl, xa})
                    $display("FAIL rand_pipe dut%0d cyc%0d got %b/%h %b/%h want %b/%h %b/%h",
                             d, c, o_er[d], o_dr[d], o_eb[d], o_db[d], xl[32], xl[31:0], xa[32], xa[31:0]);
                else n_pass++;
                n_total++;
                if ({o_bc[d], o_td[d], o_cv[d], o_cm[d], o_err[d]} !== {8'(m_beats[d]), m_done[d], m_cv[d], m_mode[d], m_err[d]})
                    $display("FAIL rand_ctl dut%0d cyc%0d got bc=%0d td=%b cv=%b cm=%0d err=%b want bc=%0d td=%b cv=%b cm=%0d err=%b",
                             d, c, o_bc[d], o_td[d], o_cv[d], o_cm[d], o_err[d],
                             m_beats[d], m_done[d], m_cv[d], m_mode[d], m_err[d]);
                else n_pass++;
            end
        end
        repeat (6) begin drive(1'b0, 1'b0, '0); tick(); end
    endtask

    task automatic test_err();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        en_left = 1'b1; en_above = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_err[d] !== CHK_EN) $display("FAIL err_set dut%0d got %b want %b", d, o_err[d], CHK_EN);
            else n_pass++;
        end
        drive(1'b0, 1'b0, '0);
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_err[d] !== CHK_EN) $display("FAIL err_sticky dut%0d got %b want %b", d, o_err[d], CHK_EN);
            else n_pass++;
        end
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_err[d] !== 1'b0) $display("FAIL err_clear dut%0d got %b want 0", d, o_err[d]);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_zero_idle();
        test_tile();
        test_cfg();
        test_saturate_reset();
        test_random();
        test_err();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
